// File: rtl/rd_regfile_dp_pkg.sv
// rtl/rd_regfile_dp_pkg.sv - shared types, defaults and byte-merge helper for the register file
package rd_regfile_dp_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 6;

  // Upper bound on data width the merge helper can handle; callers zero-extend and truncate.
  localparam int MAX_DW = 256;
  localparam int MAX_BW = MAX_DW / 8;

  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_BW-1:0] be
  );
    logic [MAX_DW-1:0] w;
    w = old_w;
    for (int i = 0; i < MAX_BW; i++) begin
      if (be[i]) w[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/rd_regfile_clrseq.sv
// rtl/rd_regfile_clrseq.sv - clear sequencer: walks every entry writing zero, reports busy
module rd_regfile_clrseq
  import rd_regfile_dp_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int INIT_CLEAR = 1
) (
  input  logic          sys_clk,
  input  logic          resetl,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam state_e RST_ST = (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= RST_ST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (clr) begin
          cnt_d = '0;
        end else if (&cnt_q) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_READY: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RST_ST;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/rd_regfile_dp.sv
// rtl/rd_regfile_dp.sv - parametrised dual-port register file with byte enables,
// collision merge, optional read-during-write forwarding and hardware clear
module rd_regfile_dp
  import rd_regfile_dp_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int AW         = DEF_AW,
  parameter int BW         = DW / 8,
  parameter int FWD        = 1,
  parameter int B_WINS     = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic          sys_clk,
  input  logic          resetl,
  input  logic          ena,
  input  logic          nwea,
  input  logic [BW-1:0] bea,
  input  logic [AW-1:0] aa,
  input  logic [DW-1:0] da,
  output logic [DW-1:0] qa,
  input  logic          enb,
  input  logic          nweb,
  input  logic [BW-1:0] beb,
  input  logic [AW-1:0] ab,
  input  logic [DW-1:0] db,
  output logic [DW-1:0] qb,
  input  logic          clr,
  output logic          busy
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  rd_regfile_clrseq #(
    .AW         (AW),
    .INIT_CLEAR (INIT_CLEAR)
  ) u_clrseq (
    .sys_clk  (sys_clk),
    .resetl   (resetl),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic wea, web, hit;
  assign wea = ena & ~nwea & ~busy;
  assign web = enb & ~nweb & ~busy;
  assign hit = (aa == ab);

  // Byte masks each port contributes to the word at each address.
  logic [MAX_BW-1:0] bea_at_a, beb_at_a, bea_at_b, beb_at_b;
  assign bea_at_a = wea         ? MAX_BW'(bea) : '0;
  assign beb_at_a = (web & hit) ? MAX_BW'(beb) : '0;
  assign bea_at_b = (wea & hit) ? MAX_BW'(bea) : '0;
  assign beb_at_b = web         ? MAX_BW'(beb) : '0;

  // Post-write word at each address; the priority port is merged last so it wins shared bytes.
  logic [DW-1:0] post_a, post_b;

  generate
    if (B_WINS != 0) begin : g_b_wins
      assign post_a = DW'(byte_merge(byte_merge(MAX_DW'(mem[aa]), MAX_DW'(da), bea_at_a),
                                     MAX_DW'(db), beb_at_a));
      assign post_b = DW'(byte_merge(byte_merge(MAX_DW'(mem[ab]), MAX_DW'(da), bea_at_b),
                                     MAX_DW'(db), beb_at_b));
    end else begin : g_a_wins
      assign post_a = DW'(byte_merge(byte_merge(MAX_DW'(mem[aa]), MAX_DW'(db), beb_at_a),
                                     MAX_DW'(da), bea_at_a));
      assign post_b = DW'(byte_merge(byte_merge(MAX_DW'(mem[ab]), MAX_DW'(db), beb_at_b),
                                     MAX_DW'(da), bea_at_b));
    end
  endgenerate

  // On a collision both ports write the same merged word, so the double write is harmless.
  always_ff @(posedge sys_clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else begin
      if (wea) mem[aa] <= post_a;
      if (web) mem[ab] <= post_b;
    end
  end

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      qa <= '0;
      qb <= '0;
    end else if (busy) begin
      qa <= '0;
      qb <= '0;
    end else begin
      if (ena) qa <= (FWD != 0) ? post_a : mem[aa];
      if (enb) qb <= (FWD != 0) ? post_b : mem[ab];
    end
  end

endmodule

// File: doc/rd_regfile_dp.md
Name: rd_regfile_dp

Overview:
- Parametrised dual-port register file, successor to the fixed 64x32 GPU/DSP register RAM.
- Adds generic width and depth, per-port byte enables, and deterministic same-address collision handling.
- Adds optional read-during-write forwarding and a hardware clear sequencer that zeroes every entry after reset or on request.
- Sits between the RISC core's operand fetch / writeback stages and the register storage.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- AW, 6, address width; DEPTH = 2**AW entries.
- BW, DW/8, byte-enable width (derived; do not override).
- FWD, 1, 1 = read-during-write returns the new (merged) data on both ports; 0 = returns the old data.
- B_WINS, 1, 1 = port B has byte priority on same-address write collision; 0 = port A has priority.
- INIT_CLEAR, 1, 1 = run the clear sequence after reset; 0 = come out of reset READY with contents undefined.

Ports:
- sys_clk  in  1  single clock; all logic is on the rising edge.
- resetl  in  1  asynchronous active-low reset.
- ena  in  1  port A access enable.
- nwea  in  1  port A write strobe, active low; qualified by ena.
- bea  in  BW  port A byte enables.
- aa  in  AW  port A address.
- da  in  DW  port A write data.
- qa  out  DW  port A read data, registered.
- enb  in  1  port B access enable.
- nweb  in  1  port B write strobe, active low; qualified by enb.
- beb  in  BW  port B byte enables.
- ab  in  AW  port B address.
- db  in  DW  port B write data.
- qb  out  DW  port B read data, registered.
- clr  in  1  synchronous request to re-run the clear sequence.
- busy  out  1  high while the clear sequence is running.

Behaviour:
- Reset (resetl low, asynchronous):
  - qa = 0, qb = 0.
  - Clear counter = 0.
  - State = CLEAR if INIT_CLEAR, else READY.
  - busy = INIT_CLEAR.
  - Array contents are not reset directly.
- State machine with two states, CLEAR and READY.
  - CLEAR: each cycle writes 0 to entry cnt, then cnt increments.
  - When cnt = DEPTH-1 is written, the next state is READY, cnt wraps to 0 and busy falls on the same edge.
  - Clearing takes exactly DEPTH cycles.
  - READY -> CLEAR when clr = 1 at a clock edge. clr in CLEAR restarts cnt at 0.
- Accesses during CLEAR:
  - All port writes are dropped.
  - qa and qb are forced to 0 on every edge.
  - No error is flagged; the issuing master must respect busy.
- Write (READY only): wea = ena & ~nwea. Byte i of mem[aa] is updated when wea & bea[i]. Port B likewise.
- Read:
  - When ena = 1, qa <= mem[aa] one cycle later (latency 1).
  - When ena = 0, qa holds its value.
  - A write does not suppress the read: a writing port also returns read data.
- Collision (aa == ab, both writing):
  - Bytes are merged per byte.
  - A byte enabled on both ports takes the data of the priority port (B if B_WINS, else A).
  - Non-overlapping enabled bytes from both ports are all written.
- Read-during-write, same or other port, same address, same cycle:
  - FWD = 1: q returns the post-write merged word.
  - FWD = 0: q returns the pre-write word.
- Both ports reading the same address with no write: both return identical data.
- Address width: addresses are full width, so there is no out-of-range case.
- Reset asserted mid-clear or mid-access: all in-flight effects are abandoned. After release the clear sequence starts from cnt = 0 (if INIT_CLEAR).

Decomposition:
- Shared package (the GPU/DSP common package) holds:
  - state encoding: ST_CLEAR, ST_READY;
  - default DW and AW constants;
  - a byte-merge function: (old, new, be) -> word.
- One sub-module, rd_regfile_clrseq: the state machine, counter and busy. It outputs a clear-write enable and clear address.
- Storage, merge and forwarding logic live in the top level.

Test Plan:
- Reset then release, INIT_CLEAR=1, AW=6 -> busy high for exactly 64 cycles. Afterwards reading all 64 addresses returns 0x00000000.
- READY; A writes aa=5, da=0x12345678, bea=4'b1111; next cycle A reads 5 -> qa = 0x12345678 one cycle after the read request.
- Collision on address 9 (prior contents 0), B_WINS=1:
  - stimulus: A writes 0xAAAAAAAA with bea=4'b0011; B writes 0xBBBBBBBB with beb=4'b0110;
  - response: mem[9] = 0x00BBBBAA.
- Forwarding, FWD=1, address 3 holding 0x11111111:
  - stimulus: A writes 0xCAFEF00D to 3 while B reads 3;
  - response: qb = 0xCAFEF00D.
  - With FWD=0 the same stimulus gives qb = 0x11111111.
- Writes while busy:
  - stimulus: assert clr in READY; next cycle A writes 0xFFFFFFFF to 2;
  - response: after busy falls, mem[2] = 0. qa reads 0 throughout CLEAR.
- Reset mid-clear:
  - stimulus: pull resetl low at cnt = 20, then release;
  - response: qa = qb = 0 immediately on assertion. busy lasts a full 64 cycles from release.
